// File: rtl/pong_pkg.sv
// Shared pong types: FSM encoding, position widths and default screen centre.
package pong_pkg;

  localparam int unsigned X_W          = 10;
  localparam int unsigned Y_W          = 9;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;
  localparam int unsigned CENTER_X     = SCREEN_W_DEF / 2;
  localparam int unsigned CENTER_Y     = SCREEN_H_DEF / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

endpackage

// File: rtl/ball_ctrl.sv
// Frame-rate ball motion controller: serve/play/score sequencing and ball position.
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H    = SCREEN_H_DEF,
  parameter int unsigned BALL_SIZE   = 10,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned SERVE_DELAY = 60
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_tick,
  input  logic           start,
  input  logic           coll_l,
  input  logic           coll_r,
  output logic [X_W-1:0] ball_x,
  output logic [Y_W-1:0] ball_y,
  output logic           in_play,
  output logic           score_l,
  output logic           score_r
);

  // 11-bit intermediates keep every bound check and step free of wrap-around.
  localparam int unsigned AW = 11;
  localparam logic [X_W-1:0]   CX     = X_W'(SCREEN_W / 2);
  localparam logic [Y_W-1:0]   CY     = Y_W'(SCREEN_H / 2);
  localparam logic [AW-1:0]    HALF   = AW'(BALL_SIZE / 2);
  localparam logic [AW-1:0]    SPD    = AW'(SPEED);
  localparam logic [AW-1:0]    X_MAX  = AW'(SCREEN_W - 1);
  localparam logic [AW-1:0]    Y_MAX  = AW'(SCREEN_H - 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SERVE_DELAY);

  state_t           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             dir_x_q, dir_x_d;
  logic             dir_y_q, dir_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_play_q, score_l_q, score_r_q;
  logic             score_l_d, score_r_d;
  logic             dx, dy, bounce;
  logic [AW-1:0]    x_w, y_w;

  assign x_w = AW'(x_q);
  assign y_w = AW'(y_q);

  // State, position, direction, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= CX;
      y_q       <= CY;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      cnt_q     <= '0;
      in_play_q <= 1'b0;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      cnt_q     <= cnt_d;
      in_play_q <= (state_d == ST_PLAY);
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  // Next-state: serve countdown, then per-tick bounce, score and step in priority order.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    cnt_d     = cnt_q;
    score_l_d = 1'b0;
    score_r_d = 1'b0;
    dx        = dir_x_q;
    dy        = dir_y_q;
    bounce    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SERVE;
          cnt_d   = RELOAD;
        end
      end

      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      ST_PLAY: begin
        if (frame_tick) begin
          if (coll_l && !dx) begin
            dx     = 1'b1;
            bounce = 1'b1;
          end else if (coll_r && dx) begin
            dx     = 1'b0;
            bounce = 1'b1;
          end
          if (!dy && (y_w < HALF + SPD)) begin
            dy = 1'b1;
          end else if (dy && (y_w + HALF + SPD > Y_MAX)) begin
            dy = 1'b0;
          end

          if (!bounce && !dx && (x_w < HALF + SPD)) begin
            score_r_d = 1'b1;
            x_d       = CX;
            y_d       = CY;
            dir_x_d   = 1'b0;
            dir_y_d   = ~dy;
            state_d   = ST_SERVE;
            cnt_d     = RELOAD;
          end else if (!bounce && dx && (x_w + HALF + SPD > X_MAX)) begin
            score_l_d = 1'b1;
            x_d       = CX;
            y_d       = CY;
            dir_x_d   = 1'b1;
            dir_y_d   = ~dy;
            state_d   = ST_SERVE;
            cnt_d     = RELOAD;
          end else begin
            dir_x_d = dx;
            dir_y_d = dy;
            x_d     = X_W'(dx ? (x_w + SPD) : (x_w - SPD));
            y_d     = Y_W'(dy ? (y_w + SPD) : (y_w - SPD));
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign ball_x  = x_q;
  assign ball_y  = y_q;
  assign in_play = in_play_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;

endmodule
